// File: rtl/seed_ram_write.sv
`default_nettype none
// ============================================================================
// Module  : seed_ram_write
// Brief   : Serialises a WORDS x 32-bit seed into a single-port RAM, MSW first,
//           one word per two clocks, with load_en/load_ack and done/done_ack.
// Revision: 1.0
// ============================================================================
module seed_ram_write #(
  parameter int WORDS     = 96,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                load_en,
  input  logic [32*WORDS-1:0] data_in,
  input  logic                done_ack,
  output logic                load_ack,
  output logic [6:0]          ram_addr,
  output logic [31:0]         ram_data,
  output logic                ram_write,
  output logic                busy,
  output logic                done
);

  localparam int         c_VEC_W = 32 * WORDS;
  localparam logic [6:0] c_BASE  = 7'(BASE_ADDR);
  localparam logic [6:0] c_LAST  = 7'(WORDS - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_NEXT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [c_VEC_W-1:0] r_shreg;
  logic [6:0]         r_cnt;
  logic               r_load_ack;
  logic [6:0]         r_ram_addr;
  logic [31:0]        r_ram_data;
  logic               r_ram_write;
  logic               r_busy;
  logic               r_done;

  // Word 0 is the MSW, so the top slice of the shifter is always the next word out.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_load_ack  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (load_en) begin
            r_shreg    <= data_in;
            r_cnt      <= '0;
            r_load_ack <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= c_WRITE;
          end
        end
        c_WRITE: begin
          r_ram_addr  <= c_BASE + r_cnt;
          r_ram_data  <= r_shreg[c_VEC_W-1 -: 32];
          r_ram_write <= 1'b1;
          r_state     <= c_NEXT;
        end
        c_NEXT: begin
          r_ram_write <= 1'b0;
          r_shreg     <= r_shreg << 32;
          r_cnt       <= r_cnt + 7'd1;
          if (r_cnt == c_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_state <= c_WRITE;
          end
        end
        c_DONE: begin
          r_ram_write <= 1'b0;
          if (done_ack) begin
            r_done  <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign load_ack  = r_load_ack;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_write = r_ram_write;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seed_ram_write.sv
`default_nettype none
// ============================================================================
// Module  : tb_seed_ram_write
// Brief   : Vector table on a 2-word instance at the top of the address map,
//           directed multi-cycle sequences on the default 96-word instance.
// Revision: 1.0
// ============================================================================
module tb_seed_ram_write;

  localparam int W  = 96;
  localparam int VW = 32 * W;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          load_en, done_ack;
  logic [VW-1:0] data_in;
  logic          load_ack, ram_write, busy, done;
  logic [6:0]    ram_addr;
  logic [31:0]   ram_data;

  logic          s_load_en, s_done_ack;
  logic [63:0]   s_data_in;
  logic          s_load_ack, s_ram_write, s_busy, s_done;
  logic [6:0]    s_ram_addr;
  logic [31:0]   s_ram_data;

  always #5 clk_in = ~clk_in;

  seed_ram_write #(.WORDS(W), .BASE_ADDR(0)) u_dut (
    .clk_in(clk_in), .rst(rst), .load_en(load_en), .data_in(data_in),
    .done_ack(done_ack), .load_ack(load_ack), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_write(ram_write), .busy(busy), .done(done)
  );

  seed_ram_write #(.WORDS(2), .BASE_ADDR(126)) u_dut_small (
    .clk_in(clk_in), .rst(rst), .load_en(s_load_en), .data_in(s_data_in),
    .done_ack(s_done_ack), .load_ack(s_load_ack), .ram_addr(s_ram_addr),
    .ram_data(s_ram_data), .ram_write(s_ram_write), .busy(s_busy), .done(s_done)
  );

  int total = 0;
  int bad   = 0;

  // RAM model: samples on the edge that ends a strobe cycle.
  logic [31:0] mem [128];
  longint      wr_time [128];
  int          captures = 0;

  always @(posedge clk_in) begin
    if (ram_write) begin
      mem[ram_addr]     <= ram_data;
      wr_time[ram_addr] <= longint'($time);
    end
    if (load_ack) captures <= captures + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [VW-1:0] v, input int k);
    return v[VW-1-32*k -: 32];
  endfunction

  function automatic logic [VW-1:0] make_vec(input int mode);
    logic [VW-1:0] v;
    logic [31:0]   w;
    v = '0;
    for (int k = 0; k < W; k++) begin
      case (mode)
        0:       w = 32'hA000_0000 + 32'(k);
        1:       w = (k == 0) ? 32'hDEAD_BEEF : (k == W-1) ? 32'h0000_0001
                               : (32'h5A5A_0000 ^ 32'(k * 7919));
        default: w = 32'h0F0F_F0F0 + 32'(k * 3);
      endcase
      v[VW-1-32*k -: 32] = w;
    end
    return v;
  endfunction

  task automatic roundtrip(input string name, input logic [VW-1:0] vec);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r = (r << 32) | VW'(mem[k]);
    total++;
    if (r !== vec) begin
      bad++;
      for (int k = 0; k < W; k++)
        if (wd(r, k) !== wd(vec, k)) begin
          $display("FAIL %s: word %0d got %h expected %h", name, k, wd(r, k), wd(vec, k));
          break;
        end
    end
  endtask

  // Capture edge: caller has data_in set and the DUT sits in IDLE.
  task automatic capture(input bit hold);
    load_en = 1'b1;
    @(posedge clk_in); #1;
    chk("load_ack_at_capture", {62'd0, load_ack, busy}, 64'd3);
    if (!hold) load_en = 1'b0;
  endtask

  // Follows the 2*W cycles after the capture edge, checking every strobe slot.
  task automatic run_check(input logic [VW-1:0] vec, input bit disturb);
    int gap_err;
    gap_err = 0;
    for (int i = 1; i <= 2*W; i++) begin
      @(posedge clk_in); #1;
      if (i == 1) chk("load_ack_one_cycle", {63'd0, load_ack}, 64'd0);
      if (i % 2 == 1)
        chk($sformatf("strobe_word_%0d", (i-1)/2),
            {21'd0, ram_write, ram_addr, ram_data, busy, done},
            {21'd0, 1'b1, 7'((i-1)/2), wd(vec, (i-1)/2), 1'b1, 1'b0});
      else if (i < 2*W) begin
        if ({ram_write, busy, done} !== 3'b010) gap_err++;
      end else
        chk("done_after_last_word", {61'd0, ram_write, busy, done}, 64'd1);
      if (disturb) begin
        if (i == 3 || i == 150) begin
          data_in = make_vec(2);
          load_en = 1'b1;
        end else if (i == 4 || i == 151) begin
          load_en = 1'b0;
        end
      end
    end
    chk("gap_cycles_quiet", 64'(gap_err), 64'd0);
  endtask

  task automatic finish_done(input int wait_cycles);
    int err;
    err = 0;
    for (int n = 0; n < wait_cycles; n++) begin
      @(posedge clk_in); #1;
      if ({ram_write, busy, done} !== 3'b001) err++;
    end
    chk("done_hold_no_strobe", 64'(err), 64'd0);
    done_ack = 1'b1;
    @(posedge clk_in); #1;
    chk("done_cleared_by_ack", {62'd0, done, load_ack}, 64'd0);
    done_ack = 1'b0;
  endtask

  typedef struct {
    logic        le;
    logic        da;
    logic        la;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int cap0;
    int cnt_hi, cnt_lo;
    longint mark;
    logic [VW-1:0] va, vb;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0,   32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd126, 32'h1111_1111, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd126, 32'h1111_1111, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 32'h2222_2222, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 32'h2222_2222, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd126, 32'h1111_1111, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd126, 32'h1111_1111, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 32'h2222_2222, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 32'h2222_2222, 1'b0, 1'b0};

    rst = 1'b1;
    load_en = 1'b0; done_ack = 1'b0; data_in = '0;
    s_load_en = 1'b0; s_done_ack = 1'b0; s_data_in = {32'h1111_1111, 32'h2222_2222};
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_outputs", {21'd0, load_ack, ram_addr, ram_data, ram_write, busy, done}, 64'd0);
    chk("reset_outputs_small",
        {21'd0, s_load_ack, s_ram_addr, s_ram_data, s_ram_write, s_busy, s_done}, 64'd0);
    rst = 1'b0;

    // Two-word instance at addresses 126/127, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      s_load_en  = tbl[i].le;
      s_done_ack = tbl[i].da;
      @(posedge clk_in); #1;
      chk($sformatf("tbl_%0d", i),
          {21'd0, s_load_ack, s_ram_write, s_ram_addr, s_ram_data, s_busy, s_done},
          {21'd0, tbl[i].la, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].bsy, tbl[i].dn});
    end
    s_load_en = 1'b0; s_done_ack = 1'b0;

    // Ramp pattern, single load_en pulse.
    va = make_vec(0);
    data_in = va;
    capture(1'b0);
    run_check(va, 1'b0);
    roundtrip("ramp_ram_contents", va);
    finish_done(2);

    // Round trip with DEADBEEF MSW and 1 LSW.
    vb = make_vec(1);
    data_in = vb;
    capture(1'b0);
    run_check(vb, 1'b0);
    roundtrip("roundtrip_deadbeef", vb);
    finish_done(1);

    // load_en held high through a whole run and across the done_ack.
    @(posedge clk_in); #1;
    cap0 = captures;
    data_in = va;
    capture(1'b1);
    run_check(va, 1'b0);
    finish_done(5);
    @(posedge clk_in); #1;
    chk("recapture_after_ack", {62'd0, load_ack, busy}, 64'd3);
    load_en = 1'b0;
    run_check(va, 1'b0);
    finish_done(1);
    @(posedge clk_in); #1;
    chk("capture_count_held_load_en", 64'(captures - cap0), 64'd2);

    // New data and load_en during the run must be ignored.
    cap0 = captures;
    data_in = vb;
    capture(1'b0);
    run_check(vb, 1'b1);
    roundtrip("ignore_midrun_load", vb);
    finish_done(1);
    @(posedge clk_in); #1;
    chk("capture_count_disturb", 64'(captures - cap0), 64'd1);

    // Reset in the middle of the word-40 strobe.
    mark = longint'($time);
    data_in = va;
    capture(1'b0);
    repeat (81) @(posedge clk_in);
    #1;
    chk("at_word40_strobe", {56'd0, ram_write, ram_addr}, {56'd0, 1'b1, 7'd40});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_clears",
        {21'd0, load_ack, ram_addr, ram_data, ram_write, busy, done}, 64'd0);
    @(posedge clk_in); #1;
    rst = 1'b0;
    cnt_hi = 0; cnt_lo = 0;
    for (int a = 0; a < 128; a++)
      if (wr_time[a] > mark) begin
        if (a < 40) cnt_lo++;
        else        cnt_hi++;
      end
    chk("words_0_39_written", 64'(cnt_lo), 64'd40);
    chk("words_40_up_not_written", 64'(cnt_hi), 64'd0);
    @(posedge clk_in); #1;
    chk("done_low_after_reset", {62'd0, done, busy}, 64'd0);

    data_in = vb;
    capture(1'b0);
    run_check(vb, 1'b0);
    roundtrip("full_run_after_reset", vb);
    finish_done(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
